// File: rtl/ihm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ihm_pkg
// Description : Shared state encoding and helpers for the multi-channel
//               HMI/PWM motor controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ihm_pkg;

    typedef enum logic [1:0] {
        STANDBY   = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    // Full-scale duty / counter value for a given width.
    function automatic int unsigned pwm_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ihm_pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module      : ihm_channel
// Description : One motor channel: switch debouncers, target duty, soft
//               start/stop ramp FSM and registered PWM compare.
// Revision    : 1.0 - initial release
// ============================================================================
module ihm_channel
    import ihm_pkg::*;
#(
    parameter int PWM_BITS        = 8,
    parameter int DUTY_STEP       = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start_stop,
    input  logic                i_increase,
    input  logic                i_decrease,
    input  logic                i_tick,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_running,
    output logic                o_pwm,
    output logic [PWM_BITS-1:0] o_duty
);

    localparam logic [PWM_BITS-1:0] c_MAX      = PWM_BITS'(pwm_max(PWM_BITS));
    localparam int                  c_DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PWM_BITS:0]   c_STEP     = (PWM_BITS + 1)'(DUTY_STEP);

    // Bit 0: start/stop, bit 1: increase, bit 2: decrease
    logic [2:0] w_raw;
    logic [2:0] w_stable;
    assign w_raw = {i_decrease, i_increase, i_start_stop};

    for (genvar g = 0; g < 3; g++) begin : g_deb
        logic [c_DEB_W-1:0] r_cnt;
        logic               r_val;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_val <= 1'b0;
            end else if (w_raw[g] == r_val) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DEB_LAST) begin
                r_cnt <= '0;
                r_val <= w_raw[g];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
        assign w_stable[g] = r_val;
    end

    logic [1:0]          r_btn_q;
    logic [PWM_BITS-1:0] r_target;
    logic [PWM_BITS:0]   w_ext;
    logic [PWM_BITS:0]   w_sum;
    logic                w_inc_rise;
    logic                w_dec_rise;

    assign w_inc_rise = w_stable[1] & ~r_btn_q[0];
    assign w_dec_rise = w_stable[2] & ~r_btn_q[1];
    assign w_ext      = {1'b0, r_target};
    assign w_sum      = w_ext + c_STEP;

    // A press only counts while the opposite switch is released, so
    // simultaneous presses cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q  <= 2'b00;
            r_target <= '0;
        end else begin
            r_btn_q <= w_stable[2:1];
            if (w_inc_rise && !w_stable[2]) begin
                r_target <= (w_sum > {1'b0, c_MAX}) ? c_MAX : w_sum[PWM_BITS-1:0];
            end else if (w_dec_rise && !w_stable[1]) begin
                r_target <= (w_ext < c_STEP) ? '0 : (r_target - c_STEP[PWM_BITS-1:0]);
            end
        end
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] w_duty_nxt;
    logic                w_run;
    logic                r_pwm;

    assign w_run = w_stable[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STANDBY;
            r_duty  <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_pwm   <= (i_pwm_cnt < r_duty);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        case (r_state)
            STANDBY: begin
                w_duty_nxt = '0;
                if (w_run) w_state_nxt = RAMP_UP;
            end
            RAMP_UP: begin
                if (!w_run)                 w_state_nxt = RAMP_DOWN;
                else if (r_duty == r_target) w_state_nxt = RUN;
                else if (i_tick)
                    w_duty_nxt = (r_duty < r_target) ? r_duty + 1'b1 : r_duty - 1'b1;
            end
            RUN: begin
                if (!w_run)                 w_state_nxt = RAMP_DOWN;
                else if (r_duty != r_target) w_state_nxt = RAMP_UP;
            end
            RAMP_DOWN: begin
                if (w_run)             w_state_nxt = RAMP_UP;
                else if (r_duty == '0) w_state_nxt = STANDBY;
                else if (i_tick)       w_duty_nxt  = r_duty - 1'b1;
            end
            default: begin
                w_state_nxt = STANDBY;
                w_duty_nxt  = '0;
            end
        endcase
    end

    assign o_running = (r_state != STANDBY);
    assign o_pwm     = r_pwm;
    assign o_duty    = r_duty;

endmodule
`default_nettype wire

// File: rtl/ihm_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : ihm_pwm_multi
// Description : Multi-channel HMI/PWM motor controller; shared PWM period
//               counter and ramp prescaler feeding per-channel controllers.
// Revision    : 1.0 - initial release
// ============================================================================
module ihm_pwm_multi
    import ihm_pkg::*;
#(
    parameter int CHANNELS        = 2,
    parameter int PWM_BITS        = 8,
    parameter int DUTY_STEP       = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RAMP_DIV        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          swt_start_stop,
    input  logic [CHANNELS-1:0]          swt_increase,
    input  logic [CHANNELS-1:0]          swt_decrease,
    output logic [CHANNELS-1:0]          motor_running,
    output logic [CHANNELS-1:0]          motor_pwm,
    output logic [CHANNELS*PWM_BITS-1:0] duty_level
);

    localparam logic [PWM_BITS-1:0] c_MAX      = PWM_BITS'(pwm_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] c_CNT_LAST = c_MAX - 1'b1;
    localparam int                  c_PRE_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_PRE_W-1:0]  c_PRE_LAST = c_PRE_W'(RAMP_DIV - 1);

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [c_PRE_W-1:0]  r_presc;
    logic                w_tick;

    // Period is MAX cycles so that duty=MAX yields a constant-high output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_presc   <= '0;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == c_CNT_LAST) ? '0 : r_pwm_cnt + 1'b1;
            r_presc   <= (r_presc == c_PRE_LAST) ? '0 : r_presc + 1'b1;
        end
    end

    assign w_tick = (r_presc == c_PRE_LAST);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        ihm_channel #(
            .PWM_BITS        (PWM_BITS),
            .DUTY_STEP       (DUTY_STEP),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_start_stop (swt_start_stop[g]),
            .i_increase   (swt_increase[g]),
            .i_decrease   (swt_decrease[g]),
            .i_tick       (w_tick),
            .i_pwm_cnt    (r_pwm_cnt),
            .o_running    (motor_running[g]),
            .o_pwm        (motor_pwm[g]),
            .o_duty       (duty_level[g*PWM_BITS +: PWM_BITS])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_ihm_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_ihm_pwm_multi
// Description : Self-checking bench for ihm_pwm_multi (default 2-channel
//               build plus a 4-channel/4-bit build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ihm_pwm_multi;
    import ihm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  a_ss, a_inc, a_dec, a_run, a_pwm;
    logic [15:0] a_duty;
    logic [3:0]  b_ss, b_inc, b_dec, b_run, b_pwm;
    logic [15:0] b_duty;

    ihm_pwm_multi dut_a (
        .clk(clk), .rst(rst),
        .swt_start_stop(a_ss), .swt_increase(a_inc), .swt_decrease(a_dec),
        .motor_running(a_run), .motor_pwm(a_pwm), .duty_level(a_duty)
    );

    ihm_pwm_multi #(
        .CHANNELS(4), .PWM_BITS(4), .DUTY_STEP(5), .DEBOUNCE_CYCLES(4), .RAMP_DIV(1)
    ) dut_b (
        .clk(clk), .rst(rst),
        .swt_start_stop(b_ss), .swt_increase(b_inc), .swt_decrease(b_dec),
        .motor_running(b_run), .motor_pwm(b_pwm), .duty_level(b_duty)
    );

    typedef struct {
        string  tag;
        longint val;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   model_tgt = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input longint v);
        sb.push_back('{tag, v});
    endtask

    task automatic observe(input longint obs);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int duty0();
        return int'(a_duty[7:0]);
    endfunction

    function automatic int tgt0();
        return int'(dut_a.g_ch[0].u_ch.r_target);
    endfunction

    task automatic press_inc0();
        model_tgt = (model_tgt + 16 > 255) ? 255 : model_tgt + 16;
        expect_val("tgt_inc", model_tgt);
        a_inc[0] = 1'b1; step(6);
        a_inc[0] = 1'b0; step(6);
        observe(tgt0());
    endtask

    task automatic press_dec0();
        model_tgt = (model_tgt < 16) ? 0 : model_tgt - 16;
        expect_val("tgt_dec", model_tgt);
        a_dec[0] = 1'b1; step(6);
        a_dec[0] = 1'b0; step(6);
        observe(tgt0());
    endtask

    task automatic wait_duty0(input int val, input int limit, output int n);
        n = 0;
        while (duty0() != val && n < limit) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        int n;
        int hi;
        int mn;
        int dropped;
        rst = 1'b1;
        a_ss = '0; a_inc = '0; a_dec = '0;
        b_ss = '0; b_inc = '0; b_dec = '0;
        step(3);
        expect_val("rst_duty", 0);    observe(a_duty);
        expect_val("rst_running", 0); observe(a_run);
        expect_val("rst_pwm", 0);     observe(a_pwm);
        rst = 1'b0;
        step(2);

        // Short glitch must be rejected
        expect_val("glitch_tgt", 0);
        a_inc[0] = 1'b1; step(3);
        a_inc[0] = 1'b0; step(10);
        observe(tgt0());

        // Held switch gives exactly one step
        model_tgt = 16;
        expect_val("hold_tgt", 16);
        a_inc[0] = 1'b1; step(6);
        observe(tgt0());
        expect_val("hold_long_tgt", 16);
        step(100);
        observe(tgt0());
        a_inc[0] = 1'b0; step(6);

        for (int i = 0; i < 14; i++) press_inc0();
        chk("tgt_240", tgt0(), 240);
        for (int i = 0; i < 5; i++) press_inc0();
        chk("tgt_sat_255", tgt0(), 255);
        for (int i = 0; i < 15; i++) press_dec0();
        chk("tgt_15", tgt0(), 15);
        press_dec0();
        chk("tgt_floor_0", tgt0(), 0);

        press_inc0();
        // Both switches together, then inc re-pressed while dec is held
        expect_val("both_tgt", model_tgt);
        a_inc[0] = 1'b1; a_dec[0] = 1'b1; step(8);
        observe(tgt0());
        a_inc[0] = 1'b0; step(8);
        expect_val("inc_dec_held_tgt", model_tgt);
        a_inc[0] = 1'b1; step(8);
        observe(tgt0());
        a_inc[0] = 1'b0; a_dec[0] = 1'b0; step(8);
        chk("both_release_tgt", tgt0(), model_tgt);
        press_inc0();

        // Soft start to 32
        a_ss[0] = 1'b1;
        step(6);
        chk("start_running", a_run[0], 1);
        wait_duty0(32, 300, n);
        chk("ramp_up_time_ok", (n + 6 >= 126 && n + 6 <= 140), 1);
        step(1);
        chk("state_run", int'(dut_a.g_ch[0].u_ch.r_state), int'(RUN));
        step(20);
        chk("run_duty_hold", duty0(), 32);
        hi = 0;
        for (int i = 0; i < 255; i++) begin
            step(1);
            hi += int'(a_pwm[0]);
        end
        chk("pwm_high_count", hi, 32);

        // Soft stop
        a_ss[0] = 1'b0;
        step(10);
        chk("stop_running_ramp", a_run[0], 1);
        wait_duty0(0, 300, n);
        chk("ramp_down_time_ok", (n + 10 >= 126 && n + 10 <= 140), 1);
        chk("running_at_zero", a_run[0], 1);
        step(1);
        chk("stopped_running", a_run[0], 0);

        // Reverse during ramp-down at duty 10
        a_ss[0] = 1'b1;
        wait_duty0(32, 400, n);
        chk("reramp_reached", duty0(), 32);
        step(2);
        a_ss[0] = 1'b0;
        wait_duty0(10, 300, n);
        a_ss[0] = 1'b1;
        mn = 10; dropped = 0; n = 0;
        while (duty0() != 32 && n < 400) begin
            step(1);
            n++;
            if (duty0() < mn) mn = duty0();
            if (a_run[0] == 1'b0) dropped = 1;
        end
        chk("reverse_reached", duty0(), 32);
        chk("reverse_min_ok", (mn >= 7), 1);
        chk("reverse_running", dropped, 0);

        // Reset in the middle of RUN at duty 48
        press_inc0();
        wait_duty0(48, 300, n);
        chk("reach_48", duty0(), 48);
        step(3);
        rst = 1'b1;
        model_tgt = 0;
        expect_val("midrst_duty", 0);
        expect_val("midrst_running", 0);
        expect_val("midrst_pwm", 0);
        expect_val("midrst_tgt", 0);
        step(1);
        observe(a_duty);
        observe(a_run);
        observe(a_pwm);
        observe(tgt0());
        rst = 1'b0;
        step(10);
        chk("post_rst_running", a_run[0], 1);
        chk("post_rst_duty", duty0(), 0);
        press_inc0();
        wait_duty0(16, 200, n);
        chk("post_rst_reramp", duty0(), 16);
        chk("ch1_idle_duty", a_duty[15:8], 0);
        chk("ch1_idle_running", a_run[1], 0);

        // Second build: only channel 2 runs at full scale
        for (int i = 0; i < 3; i++) begin
            expect_val("b_tgt", 5 * (i + 1));
            b_inc[2] = 1'b1; step(6);
            b_inc[2] = 1'b0; step(6);
            observe(dut_b.g_ch[2].u_ch.r_target);
        end
        b_ss[2] = 1'b1;
        n = 0;
        while (b_duty[11:8] != 4'd15 && n < 100) begin
            step(1);
            n++;
        end
        chk("b_duty_reach", b_duty[11:8], 15);
        step(3);
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (b_pwm == 4'b0100) hi++;
        end
        chk("b_pwm_only_ch2", hi, 30);
        chk("b_duty_slices", b_duty, 16'h0F00);
        chk("b_running", b_run, 4'b0100);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
